// File: rtl/mux_rr_pipe_if.sv
// mux_rr_pipe_if
// Bundles the multi-producer input side and the single-consumer output side
// of the registered round-robin multiplexer.
//   in_data   : N*WIDTH packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid from the producers
//   in_ready  : per-channel ready back to the producers (at most one high)
//   sel       : explicit channel select (only used in select mode)
//   out_data  : registered output word
//   out_valid : registered output valid
//   out_src   : index of the channel the output word came from
//   out_ready : downstream ready
// The slave modport is the multiplexer; master is whoever drives it.
interface mux_rr_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) ();
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SW-1:0]      sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [SW-1:0]      out_src;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe
// N-channel, WIDTH-bit multiplexer with one output register stage and a
// valid/ready handshake on every input and on the output. The granted channel
// is chosen either by the explicit sel input (MODE=0) or by a round-robin
// search starting just after the last channel that transferred (MODE=1).
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : mux_rr_pipe_if slave modport carrying the data/handshake signals
module mux_rr_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  mux_rr_pipe_if.slave    bus
);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic [SW-1:0]    outSrc_q, outSrc_d;
  logic             outValid_q, outValid_d;
  logic [SW-1:0]    lastGrant_q, lastGrant_d;

  logic [N-1:0]     grant;
  logic [SW-1:0]    grantIdx;
  logic             canAccept;
  logic             transfer;

  // The output register may be refilled whenever it is empty or being
  // drained in this same cycle.
  assign canAccept = !outValid_q || bus.out_ready;

  // Grant is one-hot or zero. In select mode a sel value that matches no
  // channel simply grants nothing. In round-robin mode the search visits
  // channels lastGrant+1 .. lastGrant+N (mod N) and stops at the first valid.
  always_comb begin
    int idx;
    logic found;
    grant    = '0;
    grantIdx = '0;
    idx      = 0;
    found    = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (int'(bus.sel) == i && bus.in_valid[i]) begin
          grant[i] = 1'b1;
          grantIdx = SW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(lastGrant_q) + k) % N;
        if (!found && bus.in_valid[idx]) begin
          found       = 1'b1;
          grant[idx]  = 1'b1;
          grantIdx    = SW'(idx);
        end
      end
    end
  end

  // Ready is forced low while reset is asserted so no producer sees a
  // handshake that the register will not capture.
  assign bus.in_ready = grant & {N{canAccept && !rst}};
  assign transfer     = |(bus.in_ready & bus.in_valid);

  // Next-state for the output stage: load on transfer, drop valid on a pop
  // with no replacement, otherwise hold. Data and source are kept on a pop.
  always_comb begin
    outData_d   = outData_q;
    outSrc_d    = outSrc_q;
    outValid_d  = outValid_q;
    lastGrant_d = lastGrant_q;
    if (transfer) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          outData_d = bus.in_data[i*WIDTH +: WIDTH];
        end
      end
      outSrc_d   = grantIdx;
      outValid_d = 1'b1;
      if (MODE != 0) begin
        lastGrant_d = grantIdx;
      end
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer. The pointer resets to N-1 so
  // channel 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData_q   <= '0;
      outSrc_q    <= '0;
      outValid_q  <= 1'b0;
      lastGrant_q <= SW'(N - 1);
    end else begin
      outData_q   <= outData_d;
      outSrc_q    <= outSrc_d;
      outValid_q  <= outValid_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign bus.out_data  = outData_q;
  assign bus.out_src   = outSrc_q;
  assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// tb_mux_rr_pipe
// Drives a select-mode instance and a round-robin instance of mux_rr_pipe
// (N=4, WIDTH=32) with directed vectors and hand-computed expectations.
module tb_mux_rr_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_rr_pipe_if #(.WIDTH(32), .N(4)) if0 ();
  mux_rr_pipe_if #(.WIDTH(32), .N(4)) if1 ();

  mux_rr_pipe #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  mux_rr_pipe #(.WIDTH(32), .N(4), .MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] inData;
    logic [3:0]   inValid;
    logic [1:0]   sel;
    logic         outReady;
    logic [3:0]   expInReady;
    logic         expValid;
    logic [31:0]  expData;
    logic [1:0]   expSrc;
  } vec_t;

  vec_t vecs[10];

  // Compares one value and logs any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives the select-mode instance inputs.
  task automatic applyStimulus(input logic [127:0] d, input logic [3:0] v,
                               input logic [1:0] s, input logic r);
    if0.in_data   = d;
    if0.in_valid  = v;
    if0.sel       = s;
    if0.out_ready = r;
  endtask

  // Advances to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut1(input string name, input logic v, input logic [31:0] d, input logic [1:0] s);
    checkOutput({name, " valid"}, 32'(if1.out_valid), 32'(v));
    checkOutput({name, " data"},  if1.out_data, d);
    checkOutput({name, " src"},   32'(if1.out_src), 32'(s));
  endtask

  task automatic checkOut0(input string name, input logic v, input logic [31:0] d, input logic [1:0] s);
    checkOutput({name, " valid"}, 32'(if0.out_valid), 32'(v));
    checkOutput({name, " data"},  if0.out_data, d);
    checkOutput({name, " src"},   32'(if0.out_src), 32'(s));
  endtask

  localparam logic [127:0] D0 = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'hCAFE_0000};
  localparam logic [127:0] DRR = {32'h13, 32'h12, 32'h11, 32'h10};

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(D0, 4'b1111, 2'd0, 1'b1);
    if1.in_data   = DRR;
    if1.in_valid  = 4'b1111;
    if1.sel       = 2'd0;
    if1.out_ready = 1'b1;

    // Reset state, with inputs valid to show ready stays low.
    #2;
    checkOut0("reset dut0", 1'b0, 32'h0, 2'd0);
    checkOut1("reset dut1", 1'b0, 32'h0, 2'd0);
    checkOutput("reset inReady0", 32'(if0.in_ready), 32'h0);
    checkOutput("reset inReady1", 32'(if1.in_ready), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if1.in_valid = 4'b0000;

    // Select-mode vector table.
    vecs[0] = '{D0, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2};
    vecs[1] = '{D0, 4'b1001, 2'd1, 1'b1, 4'b0000, 1'b0, 32'hDEAD_BEEF, 2'd2};
    vecs[2] = '{D0, 4'b1001, 2'd1, 1'b1, 4'b0000, 1'b0, 32'hDEAD_BEEF, 2'd2};
    vecs[3] = '{D0, 4'b1001, 2'd3, 1'b1, 4'b1000, 1'b1, 32'h3333_3333, 2'd3};
    vecs[4] = '{D0, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b1, 32'h3333_3333, 2'd3};
    vecs[5] = '{D0, 4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 32'hCAFE_0000, 2'd0};
    vecs[6] = '{D0, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 32'h1111_1111, 2'd1};
    vecs[7] = '{D0, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2};
    vecs[8] = '{D0, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 2'd2};
    vecs[9] = '{D0, 4'b0000, 2'd2, 1'b1, 4'b0000, 1'b0, 32'hDEAD_BEEF, 2'd2};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].inData, vecs[i].inValid, vecs[i].sel, vecs[i].outReady);
      #1;
      checkOutput($sformatf("vec%0d inReady", i), 32'(if0.in_ready), 32'(vecs[i].expInReady));
      step();
      checkOut0($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData, vecs[i].expSrc);
    end

    // Backpressure: hold A5 word for three stalled cycles, then accept 5A.
    applyStimulus({96'h0, 32'hA5A5_A5A5}, 4'b0001, 2'd0, 1'b1);
    step();
    checkOut0("bp load", 1'b1, 32'hA5A5_A5A5, 2'd0);
    applyStimulus({96'h0, 32'h5A5A_5A5A}, 4'b0001, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("bp stall%0d inReady", k), 32'(if0.in_ready), 32'h0);
      step();
      checkOut0($sformatf("bp stall%0d", k), 1'b1, 32'hA5A5_A5A5, 2'd0);
    end
    if0.out_ready = 1'b1;
    #1;
    checkOutput("bp release inReady", 32'(if0.in_ready), 32'h1);
    step();
    checkOut0("bp release", 1'b1, 32'h5A5A_5A5A, 2'd0);
    if0.in_valid = 4'b0000;
    step();
    checkOutput("bp drain valid", 32'(if0.out_valid), 32'h0);

    // Round-robin across all four channels, starting at channel 0.
    if1.in_valid = 4'b1111;
    #1;
    checkOutput("rr first inReady", 32'(if1.in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOut1($sformatf("rr all%0d", k), 1'b1, 32'h10 + 32'(k % 4), 2'(k % 4));
    end
    step();
    checkOut1("rr all5", 1'b1, 32'h11, 2'd1);

    // Pointer at 1 with only channels 1 and 3 valid: 3 then 1.
    if1.in_valid = 4'b1010;
    #1;
    checkOutput("rr13 a inReady", 32'(if1.in_ready), 32'h8);
    step();
    checkOut1("rr13 a", 1'b1, 32'h13, 2'd3);
    checkOutput("rr13 b inReady", 32'(if1.in_ready), 32'h2);
    step();
    checkOut1("rr13 b", 1'b1, 32'h11, 2'd1);
    if1.in_valid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      step();
      checkOut1($sformatf("rr1 only%0d", k), 1'b1, 32'h11, 2'd1);
    end

    // Move the pointer to 2 and stall with a word held.
    if1.in_valid = 4'b0100;
    step();
    checkOut1("rr pre-reset", 1'b1, 32'h12, 2'd2);
    if1.in_valid  = 4'b1111;
    if1.out_ready = 1'b0;
    step();
    checkOut1("rr stall", 1'b1, 32'h12, 2'd2);

    // Asynchronous reset between edges clears output at once.
    if1.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    checkOut1("async reset", 1'b0, 32'h0, 2'd0);
    checkOutput("async reset inReady", 32'(if1.in_ready), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post reset inReady", 32'(if1.in_ready), 32'h1);
    step();
    checkOut1("post reset", 1'b1, 32'h10, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
